// File: rtl/fuzzy_rule_scheduler.sv
// Fuzzy rule-activation sequencer: emits every active (i,j) term pair of two masks, ascending i then j.
// Optional per-scan beat counter on rule_count when FUZZY_SCHED_RULE_CNT_EN is defined.
module fuzzy_rule_scheduler #(
    parameter int unsigned N_TERMS = 3,
    parameter int unsigned IDX_W   = ($clog2(N_TERMS) < 1) ? 1 : $clog2(N_TERMS),
    parameter int unsigned ADDR_W  = ($clog2(N_TERMS * N_TERMS) < 1) ? 1 : $clog2(N_TERMS * N_TERMS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_TERMS-1:0] mask_a,
    input  logic [N_TERMS-1:0] mask_b,
    input  logic               rule_ready,
    output logic               rule_valid,
    output logic [IDX_W-1:0]   rule_idx_a,
    output logic [IDX_W-1:0]   rule_idx_b,
    output logic [ADDR_W-1:0]  rule_addr,
    output logic               rule_last,
    output logic               busy,
    output logic               done
`ifdef FUZZY_SCHED_RULE_CNT_EN
    ,
    output logic [$clog2(N_TERMS*N_TERMS+1)-1:0] rule_count
`endif
);

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    state_t             state_q, state_d;
    logic [N_TERMS-1:0] rem_a_q, rem_a_d;
    logic [N_TERMS-1:0] rem_b_q, rem_b_d;
    logic [N_TERMS-1:0] b_base_q, b_base_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_a_q, idx_a_d;
    logic [IDX_W-1:0]   idx_b_q, idx_b_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;

    function automatic logic [IDX_W-1:0] lowest(input logic [N_TERMS-1:0] x);
        lowest = '0;
        for (int unsigned k = N_TERMS; k > 0; k--) begin
            if (x[k-1]) lowest = IDX_W'(k - 1);
        end
    endfunction

    function automatic logic onehot(input logic [N_TERMS-1:0] x);
        onehot = (x != '0) && ((x & (x - N_TERMS'(1))) == '0);
    endfunction

    assign accept = (state_q == EMIT) && valid_q && rule_ready;

    // The current A term is always the lowest bit of rem_a, so no separate pointer is kept.
    always_comb begin
        state_d  = state_q;
        rem_a_d  = rem_a_q;
        rem_b_d  = rem_b_q;
        b_base_d = b_base_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_a_d  = mask_a;
                    rem_b_d  = mask_b;
                    b_base_d = mask_b;
                    state_d  = (mask_a == '0 || mask_b == '0) ? FIN : EMIT;
                end
            end
            EMIT: begin
                if (accept) begin
                    rem_b_d = rem_b_q & (rem_b_q - N_TERMS'(1));
                    if (rem_b_d == '0) begin
                        rem_a_d = rem_a_q & (rem_a_q - N_TERMS'(1));
                        rem_b_d = b_base_q;
                        if (rem_a_d == '0) state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are precomputed from next state so every port comes straight from a flop.
    always_comb begin
        valid_d = (state_d == EMIT);
        idx_a_d = valid_d ? lowest(rem_a_d) : '0;
        idx_b_d = valid_d ? lowest(rem_b_d) : '0;
        addr_d  = ADDR_W'(idx_a_d) * ADDR_W'(N_TERMS) + ADDR_W'(idx_b_d);
        last_d  = valid_d && onehot(rem_a_d) && onehot(rem_b_d);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rem_a_q  <= '0;
            rem_b_q  <= '0;
            b_base_q <= '0;
            valid_q  <= 1'b0;
            idx_a_q  <= '0;
            idx_b_q  <= '0;
            addr_q   <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_a_q  <= rem_a_d;
            rem_b_q  <= rem_b_d;
            b_base_q <= b_base_d;
            valid_q  <= valid_d;
            idx_a_q  <= idx_a_d;
            idx_b_q  <= idx_b_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign rule_valid = valid_q;
    assign rule_idx_a = idx_a_q;
    assign rule_idx_b = idx_b_q;
    assign rule_addr  = addr_q;
    assign rule_last  = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef FUZZY_SCHED_RULE_CNT_EN
    localparam int unsigned CNT_W = $clog2(N_TERMS * N_TERMS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && start) cnt_d = '0;
        else if (accept)              cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign rule_count = cnt_q;
`endif

endmodule
